// File: rtl/sobel_window_filter.sv
`default_nettype none
// ============================================================================
//  Module      : sobel_window_filter
//  Description : Streaming 3x3 Sobel edge filter for raster-order video.
//                Owns two line buffers, x/y position counters and frame
//                sync. Output select: |Gx|, |Gy|, |Gx|+|Gy| or centre pixel.
//                Fixed two-stage latency after the accept edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module sobel_window_filter #(
    parameter int DATA_WIDTH = 12,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_val_valid,
    input  logic [DATA_WIDTH-1:0] i_val,
    input  logic                  i_sof,
    input  logic [1:0]            i_mode,
    output logic                  o_val_valid,
    output logic [DATA_WIDTH+2:0] o_val,
    output logic                  o_win_valid,
    output logic                  o_sof,
    output logic                  o_sync_err
);

    localparam int C_XW = $clog2(IMG_WIDTH);
    localparam int C_YW = $clog2(IMG_HEIGHT);
    localparam int C_OW = DATA_WIDTH + 3;

    localparam logic [1:0] C_MODE_GX   = 2'd0;
    localparam logic [1:0] C_MODE_GY   = 2'd1;
    localparam logic [1:0] C_MODE_SUM  = 2'd2;
    localparam logic [1:0] C_MODE_PASS = 2'd3;

    // Position counters, latched mode, line buffers and window
    logic [C_XW-1:0]       r_x;
    logic [C_YW-1:0]       r_y;
    logic [1:0]            r_mode;
    logic [DATA_WIDTH-1:0] r_lb1 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] r_lb2 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] r_w   [3][3];

    // Per-pixel flags travelling alongside the window (stage S0)
    logic                  r_p_valid;
    logic                  r_p_win;
    logic                  r_p_sof;

    // Stage S1 registers
    logic                  r_s1_valid;
    logic                  r_s1_win;
    logic                  r_s1_sof;
    logic [C_OW-1:0]       r_s1_res;

    // Effective position of the pixel being offered: i_sof forces (0,0)
    logic [C_XW-1:0]       w_px;
    logic [C_YW-1:0]       w_py;
    logic [DATA_WIDTH-1:0] w_lb1;
    logic [DATA_WIDTH-1:0] w_lb2;

    logic [C_OW-1:0]       w_gx_p, w_gx_n, w_gy_p, w_gy_n;
    logic [C_OW-1:0]       w_gx, w_gy, w_abs_gx, w_abs_gy;
    logic [C_OW-1:0]       w_res;

    assign w_px  = i_sof ? '0 : r_x;
    assign w_py  = i_sof ? '0 : r_y;
    assign w_lb1 = r_lb1[w_px];
    assign w_lb2 = r_lb2[w_px];

    // Operands are zero-extended so the subtraction is a plain two's
    // complement difference; raw pixels are never treated as signed.
    assign w_gx_p = C_OW'(r_w[0][0]) + (C_OW'(r_w[1][0]) << 1) + C_OW'(r_w[2][0]);
    assign w_gx_n = C_OW'(r_w[0][2]) + (C_OW'(r_w[1][2]) << 1) + C_OW'(r_w[2][2]);
    assign w_gy_p = C_OW'(r_w[0][0]) + (C_OW'(r_w[0][1]) << 1) + C_OW'(r_w[0][2]);
    assign w_gy_n = C_OW'(r_w[2][0]) + (C_OW'(r_w[2][1]) << 1) + C_OW'(r_w[2][2]);
    assign w_gx   = w_gx_p - w_gx_n;
    assign w_gy   = w_gy_p - w_gy_n;
    assign w_abs_gx = w_gx[C_OW-1] ? (C_OW'(0) - w_gx) : w_gx;
    assign w_abs_gy = w_gy[C_OW-1] ? (C_OW'(0) - w_gy) : w_gy;

    // Result select by the mode latched at the frame's i_sof
    always_comb begin
        w_res = '0;
        case (r_mode)
            C_MODE_GX:   w_res = w_abs_gx;
            C_MODE_GY:   w_res = w_abs_gy;
            C_MODE_SUM:  w_res = w_abs_gx + w_abs_gy;
            C_MODE_PASS: w_res = C_OW'(r_w[1][1]);
            default:     w_res = '0;
        endcase
    end

    // Line buffers: contents are masked by window validity, so no reset
    always_ff @(posedge i_clk) begin
        if (i_val_valid) begin
            r_lb1[w_px] <= i_val;
            r_lb2[w_px] <= w_lb1;
        end
    end

    // Counters, frame sync, mode latch, window shift and pixel flags
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_x        <= '0;
            r_y        <= '0;
            r_mode     <= C_MODE_SUM;
            o_sync_err <= 1'b0;
            r_p_valid  <= 1'b0;
            r_p_win    <= 1'b0;
            r_p_sof    <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    r_w[r][c] <= '0;
                end
            end
        end else begin
            r_p_valid <= i_val_valid;
            if (i_val_valid) begin
                if (i_sof) begin
                    r_mode <= i_mode;
                    if ((r_x != '0) || (r_y != '0)) begin
                        o_sync_err <= 1'b1;
                    end
                end
                if (w_px == C_XW'(IMG_WIDTH - 1)) begin
                    r_x <= '0;
                    r_y <= (w_py == C_YW'(IMG_HEIGHT - 1)) ? '0 : w_py + C_YW'(1);
                end else begin
                    r_x <= w_px + C_XW'(1);
                    r_y <= w_py;
                end
                for (int r = 0; r < 3; r++) begin
                    r_w[r][2] <= r_w[r][1];
                    r_w[r][1] <= r_w[r][0];
                end
                r_w[0][0] <= i_val;
                r_w[1][0] <= w_lb1;
                r_w[2][0] <= w_lb2;
                r_p_win   <= (w_px >= C_XW'(2)) && (w_py >= C_YW'(2));
                r_p_sof   <= i_sof;
            end
        end
    end

    // Stage S1: register the selected arithmetic result
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_win   <= 1'b0;
            r_s1_sof   <= 1'b0;
            r_s1_res   <= '0;
        end else begin
            r_s1_valid <= r_p_valid;
            r_s1_win   <= r_p_valid & r_p_win;
            r_s1_sof   <= r_p_valid & r_p_sof;
            if (r_p_valid) begin
                r_s1_res <= w_res;
            end
        end
    end

    // Stage S2: output strobe; o_val holds between strobes
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_val_valid <= 1'b0;
            o_win_valid <= 1'b0;
            o_sof       <= 1'b0;
            o_val       <= '0;
        end else begin
            o_val_valid <= r_s1_valid;
            o_win_valid <= r_s1_win;
            o_sof       <= r_s1_sof;
            if (r_s1_valid) begin
                o_val <= r_s1_win ? r_s1_res : '0;
            end
        end
    end

endmodule
`default_nettype wire
